// File: rtl/siso_shift_ctrl_pkg.sv
// Shared types for the SISO shift sequencer.
// State encodings, FSM enum and parity helper.
package siso_shift_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    PAR   = ST_PAR,
    DONE  = ST_DONE
  } siso_state_t;

  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/siso_shift_ctrl_if.sv
// Parallel word handshake into the SISO sequencer.
// master = producer, slave = sequencer.
interface siso_shift_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/siso_bit_cnt.sv
// Bit position counter for serialisers.
// Clear wins over increment; last flags WIDTH-1.
module siso_bit_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear, step or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/siso_shift_ctrl.sv
// Serialises parallel words LSB-first for a SISO chain.
// Optional parity bit: define SISO_SHIFT_CTRL_PARITY_EN.
module siso_shift_ctrl
  import siso_shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  siso_shift_ctrl_if.slave      in_if,
  input  logic                  abort_i,
  output logic                  ser_out_o,
  output logic                  shift_en_o,
  output logic                  frame_o,
  output logic                  busy_o,
  output logic                  done_o
);

  siso_state_t      state_q;
  siso_state_t      state_d;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;
  logic             kill;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             in_ready;
  logic             par_bit;

  assign accept = (state_q == IDLE) && in_if.in_valid;
  assign kill   = abort_i &&
                  ((state_q == SHIFT) || (state_q == PAR));

  assign cnt_clr = accept || kill ||
                   ((state_q == SHIFT) && last);
  assign cnt_inc = (state_q == SHIFT) && !abort_i && !last;

  siso_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .last_o (last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_if.in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (last) begin
`ifdef SISO_SHIFT_CTRL_PARITY_EN
          state_d = PAR;
`else
          state_d = DONE;
`endif
        end
      end
      PAR: begin
        state_d = abort_i ? IDLE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // shadow word: load on capture, drain LSB-first while shifting
  always_comb begin
    shadow_d = shadow_q;
    if (accept) begin
      shadow_d = in_if.in_data;
    end else if (kill) begin
      shadow_d = '0;
    end else if (state_q == SHIFT) begin
      shadow_d = shadow_q >> 1;
    end
  end

  // shadow register
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

`ifdef SISO_SHIFT_CTRL_PARITY_EN
  logic par_q;

  // parity of the captured word, sent after the data bits
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= even_par(32'(in_if.in_data));
    end
  end

  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  // output decode from state and registers
  always_comb begin
    in_ready   = 1'b0;
    ser_out_o  = 1'b0;
    shift_en_o = 1'b0;
    frame_o    = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        busy_o   = 1'b0;
      end
      SHIFT: begin
        shift_en_o = 1'b1;
        ser_out_o  = shadow_q[0];
        frame_o    = (cnt == '0);
      end
      PAR: begin
        shift_en_o = 1'b1;
        ser_out_o  = par_bit;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  assign in_if.in_ready = in_ready;

endmodule
